// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for the register-file write port (optional busy scoreboard: RF_SCOREBOARD_EN)
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [5*NUM_REQ-1:0]    req_rd_i,
  input  logic [XLEN*NUM_REQ-1:0] req_data_i,
  output logic                    wb_en_o,
  output logic [4:0]              wb_rd_o,
  output logic [XLEN-1:0]         wb_data_o,
  input  logic                    alloc_valid_i,
  input  logic [4:0]              alloc_rd_i,
  input  logic [4:0]              rs1_label_i,
  input  logic [4:0]              rs2_label_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0]   rr_q, rr_d, gnt_idx;
  logic            gnt_vld;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wb_en_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  // Scan from rr_q for the first non-x0 request; x0 requests are acked without a grant
  always_comb begin
    int idx;
    idx = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_vld && req_valid_i[idx] && req_rd_i[5*idx +: 5] != 5'd0) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      req_ready_o[i] = rst_ni && req_valid_i[i] &&
                       (req_rd_i[5*i +: 5] == 5'd0 || (gnt_vld && gnt_idx == PW'(i)));
    sel_rd = req_rd_i[5*gnt_idx +: 5];
    sel_data = req_data_i[XLEN*gnt_idx +: XLEN];
    rr_d = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end
  // Write stage: latch the granted write, hold rd/data when idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      rr_q      <= '0;
    end else begin
      wb_en_q <= gnt_vld;
      if (gnt_vld) begin
        wb_rd_q   <= sel_rd;
        wb_data_q <= sel_data;
        rr_q      <= rr_d;
      end
    end
  end
  assign wb_en_o   = wb_en_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;
`ifdef RF_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  // Clear on completed write, then set on new reservation so a same-edge re-alloc wins
  always_comb begin
    busy_d = busy_q;
    if (wb_en_q) busy_d[wb_rd_q] = 1'b0;
    if (alloc_valid_i && alloc_rd_i != 5'd0) busy_d[alloc_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // Busy bitmap register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign rs1_busy_o = busy_q[rs1_label_i];
  assign rs2_busy_o = busy_q[rs2_label_i];
`else
  logic unused_sb;
  assign unused_sb  = ^{alloc_valid_i, alloc_rd_i, rs1_label_i, rs2_label_i};
  assign rs1_busy_o = 1'b0;
  assign rs2_busy_o = 1'b0;
`endif
endmodule
